// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and the coordinate type.
package vga_pkg;
   typedef logic [9:0] coord_t;
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster coordinates, syncs, blanking and frame strobes.
interface vga_timing_gen_if;
   import vga_pkg::*;
   logic        hs;
   logic        vs;
   logic        blank;
   coord_t      DrawX;
   coord_t      DrawY;
   logic        frame_start;
   logic        vblank_start;
   logic [15:0] frame_count;
   modport master (output hs, vs, blank, DrawX, DrawY, frame_start, vblank_start, frame_count);
   modport slave  (input  hs, vs, blank, DrawX, DrawY, frame_start, vblank_start, frame_count);
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MOD counter with enable; exposes its next value for aligned decode.
module wrap_counter
   import vga_pkg::*;
#(
   parameter int unsigned MOD = 800,
   parameter int unsigned RST = MOD - 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en_i,
   output coord_t cnt_o,
   output coord_t cnt_d_o,
   output logic   wrap_o
);
   coord_t cnt_q, cnt_d;
   always_comb begin
      wrap_o = en_i && cnt_q == coord_t'(MOD - 1);
      cnt_d  = wrap_o ? '0 : en_i ? cnt_q + 10'd1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= coord_t'(RST);
      else cnt_q <= cnt_d;
   assign cnt_o   = cnt_q;
   assign cnt_d_o = cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; every registered output is decoded from the
// next counter values so it lines up with the DrawX/DrawY it describes.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
   parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
   parameter int unsigned H_BACK    = vga_pkg::H_BACK,
   parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
   parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
   parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);
   import vga_pkg::*;
   localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam coord_t HV  = coord_t'(H_VISIBLE);
   localparam coord_t HS0 = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS1 = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VV  = coord_t'(V_VISIBLE);
   localparam coord_t VS0 = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS1 = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
   if (HT > 1024 || VT > 1024) begin : g_size_chk
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
   end
   coord_t      hc, vc, hc_d, vc_d;
   logic        h_wrap, v_wrap;
   logic        hs_q, vs_q, blank_q, fs_q, vbs_q;
   logic        hs_d, vs_d, blank_d, vbs_d;
   logic [15:0] fc_q;
   wrap_counter #(.MOD(HT)) u_h (
      .clk(vga_clk), .rst_n(reset_n), .en_i(1'b1),
      .cnt_o(hc), .cnt_d_o(hc_d), .wrap_o(h_wrap)
   );
   wrap_counter #(.MOD(VT)) u_v (
      .clk(vga_clk), .rst_n(reset_n), .en_i(h_wrap),
      .cnt_o(vc), .cnt_d_o(vc_d), .wrap_o(v_wrap)
   );
   // v_wrap already implies h_wrap, so it alone means the next position is (0,0)
   always_comb begin
      hs_d    = !(hc_d >= HS0 && hc_d < HS1);
      vs_d    = !(vc_d >= VS0 && vc_d < VS1);
      blank_d = hc_d < HV && vc_d < VV;
      vbs_d   = hc_d == '0 && vc_d == VV;
   end
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         fs_q    <= 1'b0;
         vbs_q   <= 1'b0;
         fc_q    <= '0;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         fs_q    <= v_wrap;
         vbs_q   <= vbs_d;
         fc_q    <= fc_q + 16'(v_wrap);
      end
   assign vga.DrawX        = hc;
   assign vga.DrawY        = vc;
   assign vga.hs           = hs_q;
   assign vga.vs           = vs_q;
   assign vga.blank        = blank_q;
   assign vga.frame_start  = fs_q;
   assign vga.vblank_start = vbs_q;
   assign vga.frame_count  = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size instance checks reset and the first line from a table;
// a shrunken instance runs several frames and random mid-frame resets against a model.
module tb_vga_timing_gen;
   localparam int BHV = 16, BHF = 4, BHS = 6, BHB = 4;
   localparam int BVV = 12, BVF = 2, BVS = 2, BVB = 3;
   localparam int BHT = BHV + BHF + BHS + BHB;
   localparam int BVT = BVV + BVF + BVS + BVB;
   localparam int BFR = BHT * BVT;

   typedef struct {
      int cyc; int x; int y; bit hs; bit vs; bit blank; bit fs; int fc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int total = 0;
   int bad = 0;
   int n_b = 0;
   int vs_low = 0, bl_hi = 0, hs_low = 0;
   int fc_at_fs[$];

   vga_timing_gen_if ia();
   vga_timing_gen_if ib();

   vga_timing_gen dut_a (.vga_clk(clk), .reset_n(rst_a), .vga(ia));
   vga_timing_gen #(
      .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
   ) dut_b (.vga_clk(clk), .reset_n(rst_b), .vga(ib));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // n = clock edges since reset release; n==0 means still in (or just entered) reset
   task automatic check_b(input int n);
      int p, x, y, fc;
      bit hs, vs, bl, fs, vb;
      if (n == 0) begin
         x = BHT - 1; y = BVT - 1; hs = 1; vs = 1; bl = 0; fs = 0; vb = 0; fc = 0;
      end else begin
         p  = n - 1;
         x  = p % BHT;
         y  = (p / BHT) % BVT;
         hs = !(x >= BHV + BHF && x < BHV + BHF + BHS);
         vs = !(y >= BVV + BVF && y < BVV + BVF + BVS);
         bl = x < BHV && y < BVV;
         fs = x == 0 && y == 0;
         vb = x == 0 && y == BVV;
         fc = (p / BFR + 1) % 65536;
      end
      chk("b_DrawX", int'(ib.DrawX), x);
      chk("b_DrawY", int'(ib.DrawY), y);
      chk("b_hs", int'(ib.hs), int'(hs));
      chk("b_vs", int'(ib.vs), int'(vs));
      chk("b_blank", int'(ib.blank), int'(bl));
      chk("b_frame_start", int'(ib.frame_start), int'(fs));
      chk("b_vblank_start", int'(ib.vblank_start), int'(vb));
      chk("b_frame_count", int'(ib.frame_count), fc);
   endtask

   task automatic run_b(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         if (rst_b) n_b++;
         #1;
         check_b(n_b);
         if (n_b > BFR && n_b <= 2 * BFR) begin
            vs_low += int'(!ib.vs);
            bl_hi  += int'(ib.blank);
            hs_low += int'(!ib.hs);
         end
         if (ib.frame_start) fc_at_fs.push_back(int'(ib.frame_count));
      end
   endtask

   initial begin
      vec_t tbl[9];
      int k;
      tbl = '{
         '{1,   0,   0, 1, 1, 1, 1, 1},
         '{640, 639, 0, 1, 1, 1, 0, 1},
         '{641, 640, 0, 1, 1, 0, 0, 1},
         '{656, 655, 0, 1, 1, 0, 0, 1},
         '{657, 656, 0, 0, 1, 0, 0, 1},
         '{752, 751, 0, 0, 1, 0, 0, 1},
         '{753, 752, 0, 1, 1, 0, 0, 1},
         '{800, 799, 0, 1, 1, 0, 0, 1},
         '{801, 0,   1, 1, 1, 1, 0, 1}
      };
      repeat (5) @(posedge clk);
      #1;
      chk("a_rst_DrawX", int'(ia.DrawX), 799);
      chk("a_rst_DrawY", int'(ia.DrawY), 524);
      chk("a_rst_hs", int'(ia.hs), 1);
      chk("a_rst_vs", int'(ia.vs), 1);
      chk("a_rst_blank", int'(ia.blank), 0);
      chk("a_rst_fs", int'(ia.frame_start), 0);
      chk("a_rst_vbs", int'(ia.vblank_start), 0);
      chk("a_rst_fc", int'(ia.frame_count), 0);
      repeat (5) @(posedge clk);
      #3 rst_a = 1'b1;
      k = 0;
      for (int i = 0; i < 9; i++) begin
         while (k < tbl[i].cyc) begin
            @(posedge clk);
            k++;
         end
         #1;
         chk($sformatf("a_x_k%0d", k), int'(ia.DrawX), tbl[i].x);
         chk($sformatf("a_y_k%0d", k), int'(ia.DrawY), tbl[i].y);
         chk($sformatf("a_hs_k%0d", k), int'(ia.hs), int'(tbl[i].hs));
         chk($sformatf("a_vs_k%0d", k), int'(ia.vs), int'(tbl[i].vs));
         chk($sformatf("a_blank_k%0d", k), int'(ia.blank), int'(tbl[i].blank));
         chk($sformatf("a_fs_k%0d", k), int'(ia.frame_start), int'(tbl[i].fs));
         chk($sformatf("a_vbs_k%0d", k), int'(ia.vblank_start), 0);
         chk($sformatf("a_fc_k%0d", k), int'(ia.frame_count), tbl[i].fc);
      end

      run_b(4);
      #3 rst_b = 1'b1;
      run_b(3 * BFR + 5);
      chk("b_vs_low_cycles", vs_low, BVS * BHT);
      chk("b_blank_hi_cycles", bl_hi, BHV * BVV);
      chk("b_hs_low_cycles", hs_low, BHS * BVT);
      chk("b_fs_pulses", fc_at_fs.size(), 4);
      for (int i = 0; i < fc_at_fs.size(); i++)
         chk($sformatf("b_fc_at_pulse%0d", i), fc_at_fs[i], i + 1);

      for (int r = 0; r < 4; r++) begin
         run_b(r == 0 ? 12 * BHT + 9 - 1 - 3 * BFR - 5 + 3 * BFR + 5 - n_b : $urandom_range(40, 2 * BFR));
         #3 rst_b = 1'b0;
         #1;
         n_b = 0;
         check_b(0);
         run_b($urandom_range(1, 3));
         #3 rst_b = 1'b1;
         run_b($urandom_range(5, BFR + 20));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
